// File: rtl/seq_mult_ext.sv
// seq_mult_ext: shift-add sequential multiplier with a req/ack handshake.
// Works on operand magnitudes and negates at the end for signed products.
// Optionally stops early once the remaining multiplier bits are all zero.
module seq_mult_ext #(
  parameter int N          = 8,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             signed_mode,
  input  logic [N-1:0]     sn,
  input  logic [N-1:0]     sbn,
  output logic             busy,
  output logic             ack,
  output logic [2*N-1:0]   tich
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [2*N-1:0]  r_a;
  logic [2*N-1:0]  r_acc;
  logic [N-1:0]    r_b;
  logic [CW-1:0]   r_cnt;
  logic            r_neg;
  logic            r_busy;
  logic            r_ack;
  logic [2*N-1:0]  r_tich;

  logic [N-1:0]    w_sn_mag;
  logic [N-1:0]    w_sbn_mag;
  logic            w_neg;
  logic            w_stop;

  // Magnitude of an operand; the most negative value maps to 2^(N-1), which
  // still fits in N unsigned bits.
  function automatic logic [N-1:0] magnitude(input logic [N-1:0] v,
                                             input logic       is_signed);
    if (is_signed && v[N-1]) begin
      return ~v + 1'b1;
    end
    return v;
  endfunction

  // Two's complement negation of the 2N-bit accumulator; zero stays zero.
  function automatic logic [2*N-1:0] apply_sign(input logic [2*N-1:0] v,
                                                input logic         neg);
    if (neg) begin
      return ~v + 1'b1;
    end
    return v;
  endfunction

  assign w_sn_mag  = magnitude(sn, signed_mode);
  assign w_sbn_mag = magnitude(sbn, signed_mode);
  assign w_neg     = signed_mode & (sn[N-1] ^ sbn[N-1]);

  // Iteration ends when all N bits are consumed, or earlier when the
  // remaining multiplier bits contribute nothing.
  assign w_stop = (r_cnt == '0) || (EARLY_TERM && (r_b == '0));

  // Control FSM and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_acc   <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_tich  <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_a     <= {{N{1'b0}}, w_sn_mag};
            r_b     <= w_sbn_mag;
            r_neg   <= w_neg;
            r_acc   <= '0;
            r_cnt   <= CW'(N);
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          if (w_stop) begin
            r_state <= DONE;
          end else begin
            if (r_b[0]) begin
              r_acc <= r_acc + r_a;
            end
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          r_tich  <= apply_sign(r_acc, r_neg);
          r_ack   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign ack  = r_ack;
  assign tich = r_tich;

endmodule

// File: tb/tb_seq_mult_ext.sv
// Testbench for seq_mult_ext: two instances (early termination on and off),
// a queue-based scoreboard per instance and a reference model built from
// plain integer arithmetic.
module tb_seq_mult_ext;

  localparam int N = 8;

  typedef struct packed {
    logic [2*N-1:0] prod;
    int             cyc;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           req1, sm1, req0, sm0;
  logic [N-1:0]   sn1, sbn1, sn0, sbn0;
  logic           busy1, ack1, busy0, ack0;
  logic [2*N-1:0] tich1, tich0;

  int   cyc;
  int   checks;
  int   errors;
  exp_t q1[$];
  exp_t q0[$];

  seq_mult_ext #(.N(N), .EARLY_TERM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req1), .signed_mode(sm1),
    .sn(sn1), .sbn(sbn1), .busy(busy1), .ack(ack1), .tich(tich1)
  );

  seq_mult_ext #(.N(N), .EARLY_TERM(1'b0)) dut_noet (
    .clk(clk), .rst_n(rst_n), .req(req0), .signed_mode(sm0),
    .sn(sn0), .sbn(sbn0), .busy(busy0), .ack(ack0), .tich(tich0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference product: interpret operands as integers and multiply.
  function automatic logic [2*N-1:0] model_prod(input bit sm, input logic [N-1:0] a,
                                                input logic [N-1:0] b);
    int          sa, sb;
    logic [31:0] p;
    if (sm) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end else begin
      sa = int'(a);
      sb = int'(b);
    end
    p = sa * sb;
    return p[2*N-1:0];
  endfunction

  // Reference latency from request cycle to ack cycle.
  function automatic int model_lat(input bit et, input bit sm, input logic [N-1:0] b);
    int          k;
    logic [31:0] m;
    if (!et) return N + 3;
    if (sm && b[N-1]) m = -int'($signed(b));
    else              m = int'(b);
    k = 0;
    for (int i = 0; i < N + 1; i++) if (m[i]) k = i + 1;
    return k + 3;
  endfunction

  // Drive one request for a single cycle and record the expected response.
  task automatic issue(input bit d, input bit sm, input logic [N-1:0] a,
                       input logic [N-1:0] b, output int ackc);
    exp_t e;
    e.prod = model_prod(sm, a, b);
    e.cyc  = cyc + model_lat(!d ? 1'b0 : 1'b1, sm, b);
    ackc   = e.cyc;
    if (d) begin
      req1 = 1'b1; sm1 = sm; sn1 = a; sbn1 = b;
      q1.push_back(e);
    end else begin
      req0 = 1'b1; sm0 = sm; sn0 = a; sbn0 = b;
      q0.push_back(e);
    end
    @(posedge clk); #1;
    req1 = 1'b0; req0 = 1'b0;
    sn1 = N'($urandom); sbn1 = N'($urandom);
    sn0 = N'($urandom); sbn0 = N'($urandom);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard monitor for the early-termination instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ack1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL et_unexpected_ack: got ack with tich %0h expected no ack (cycle %0d)", tich1, cyc);
        end else begin
          e = q1.pop_front();
          chk("et_tich", 32'(tich1), 32'(e.prod));
          chk("et_ack_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Scoreboard monitor for the full-length instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ack0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL noet_unexpected_ack: got ack with tich %0h expected no ack (cycle %0d)", tich0, cyc);
        end else begin
          e = q0.pop_front();
          chk("noet_tich", 32'(tich0), 32'(e.prod));
          chk("noet_ack_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, p0;
    cyc = 0; checks = 0; errors = 0;
    rst_n = 1'b0;
    req1 = 1'b0; sm1 = 1'b0; sn1 = '0; sbn1 = '0;
    req0 = 1'b0; sm0 = 1'b0; sn0 = '0; sbn0 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_ack", 32'(ack1), 0);
    chk("rst_tich", 32'(tich1), 0);
    chk("rst_noet_busy", 32'(busy0), 0);
    chk("rst_noet_tich", 32'(tich0), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unsigned 0xFF*0xFF with busy profile over cycles 1..11.
    issue(1'b1, 1'b0, 8'hFF, 8'hFF, a1);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk($sformatf("busy_c%0d", c), 32'(busy1), (c <= 10) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;

    // Signed and unsigned corner products.
    issue(1'b1, 1'b1, 8'h80, 8'h80, a1); wait_cyc(a1 + 1);
    issue(1'b1, 1'b1, 8'hFD, 8'h05, a1); wait_cyc(a1 + 1);
    issue(1'b1, 1'b0, 8'hFD, 8'h05, a1); wait_cyc(a1 + 1);

    // Early termination latencies, then the full-length instance.
    issue(1'b1, 1'b0, 8'h5A, 8'h00, a1); wait_cyc(a1 + 1);
    issue(1'b1, 1'b0, 8'h5A, 8'h01, a1); wait_cyc(a1 + 1);
    issue(1'b0, 1'b0, 8'h5A, 8'h01, a1); wait_cyc(a1 + 1);

    // Requests hammered while busy must be ignored.
    issue(1'b1, 1'b1, 8'hB7, 8'h6D, a1);
    while (cyc < a1) begin
      req1 = 1'b1; sm1 = 1'($urandom); sn1 = N'($urandom); sbn1 = N'($urandom);
      @(posedge clk); #1;
    end
    req1 = 1'b0;
    wait_cyc(a1 + 2);

    // Back-to-back request in the ack cycle; product holds meanwhile.
    issue(1'b1, 1'b0, 8'd7, 8'd9, a1);
    wait_cyc(a1);
    issue(1'b1, 1'b0, 8'd2, 8'd3, a2);
    repeat (a2 - a1 - 1) begin
      @(negedge clk);
      chk("tich_hold", 32'(tich1), 32'd63);
    end
    @(posedge clk); #1;
    wait_cyc(a2 + 1);

    // Asynchronous reset mid-operation.
    p0 = cyc;
    issue(1'b1, 1'b0, 8'hFF, 8'hFF, a1);
    wait_cyc(p0 + 5);
    #2 rst_n = 1'b0;
    q1.delete();
    #1;
    chk("abort_busy", 32'(busy1), 0);
    chk("abort_ack", 32'(ack1), 0);
    chk("abort_tich", 32'(tich1), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("post_abort_tich", 32'(tich1), 0);
    issue(1'b1, 1'b1, 8'hC3, 8'h7E, a1); wait_cyc(a1 + 1);

    // Randomized traffic, including ack-cycle back-to-back requests.
    for (int i = 0; i < 40; i++) begin
      issue(1'b1, 1'($urandom), N'($urandom), N'($urandom >> ($urandom_range(0, 7))), a1);
      wait_cyc(a1 + $urandom_range(0, 2));
    end
    for (int i = 0; i < 10; i++) begin
      issue(1'b0, 1'($urandom), N'($urandom), N'($urandom), a1);
      wait_cyc(a1 + $urandom_range(0, 2));
    end

    repeat (20) @(posedge clk);
    #1;
    chk("et_queue_drained", 32'(q1.size()), 0);
    chk("noet_queue_drained", 32'(q0.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
